// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the default payload width and RX FIFO depth used by the UART RX path,
// plus the byte type carried between the RX datapath and its consumers.
// No ports (package only).
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for the UART RX FIFO.
// DEPTH x DATA_W registers with one synchronous write port and one
// asynchronous read port; contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address (combinational read)
//   rdata  out  mem[raddr]
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer behind the UART RX datapath.
// Each rx_valid cycle stores rx_data; bytes leave on a first-word
// fall-through valid/ready stream with registered status flags.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rx_valid, rx_data  one frame per cycle with rx_valid=1
//   m_valid, m_data    head entry (registered), m_ready accepts it
//   count              occupancy 0..DEPTH
//   empty, full        occupancy flags
//   almost_full        count >= AFULL_TH
//   overflow           sticky drop flag, cleared by ovf_clr (set wins)
//   ovf_cnt            saturating drop counter, present only when
//                      UART_RX_FIFO_OVF_CNT_EN is defined
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = UART_DATA_W,
  parameter int unsigned DEPTH    = UART_RX_FIFO_DEPTH,
  parameter int unsigned AFULL_TH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [DATA_W-1:0]      rx_data,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AFULL_LV = PW'(AFULL_TH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_q, count_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              pop, push, drop, bypass;
  logic [DATA_W-1:0] mem_rdata;

  uart_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    pop      = m_valid_q && m_ready;
    push     = rx_valid && (!full_q || pop);
    drop     = rx_valid && full_q && !pop;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    empty_d   = (wr_ptr_d == rd_ptr_d);
    full_d    = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    afull_d   = (count_d >= AFULL_LV);
    m_valid_d = (count_d != '0);
    // The new head is the byte being written this edge when the FIFO is
    // (or becomes, after the pop) empty; it is not in the array yet.
    bypass   = push && (rd_ptr_d == wr_ptr_q);
    m_data_d = m_data_q;
    if (count_d != '0) m_data_d = bypass ? rx_data : mem_rdata;
    ovf_d = ovf_q;
    if (drop) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign overflow    = ovf_q;

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && ovf_clr) ovf_cnt_d = 8'd1;
    else if (ovf_clr) ovf_cnt_d = '0;
    else if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_valid = 1'b0;
  uart_byte_t rx_data = '0;
  logic       m_valid;
  uart_byte_t m_data;
  logic       m_ready = 1'b0;
  logic [4:0] count;
  logic       empty, full, almost_full, overflow;
  logic       ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt;
`endif

  uart_rx_fifo #(
    .DATA_W   (8),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
`ifdef UART_RX_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of stored bytes plus the sticky flags.
  uart_byte_t q[$];
  bit         ovf_m = 1'b0;
  int         ocnt_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", int'(count), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == DEPTH));
    chk("almost_full", int'(almost_full), int'(q.size() >= AFULL));
    chk("m_valid", int'(m_valid), int'(q.size() > 0));
    chk("overflow", int'(overflow), int'(ovf_m));
    if (q.size() > 0) chk("m_data", int'(m_data), int'(q[0]));
`ifdef UART_RX_FIFO_OVF_CNT_EN
    chk("ovf_cnt", int'(ovf_cnt), ocnt_m);
`endif
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, compare.
  task automatic step(input bit r, input bit v, input uart_byte_t d, input bit rdy, input bit clr);
    bit pop_m, drop_m;
    rst = r; rx_valid = v; rx_data = d; m_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    if (r) begin
      q.delete();
      ovf_m  = 1'b0;
      ocnt_m = 0;
    end else begin
      pop_m  = (q.size() > 0) && rdy;
      drop_m = v && (q.size() == DEPTH) && !pop_m;
      if (pop_m) void'(q.pop_front());
      if (v && !drop_m) q.push_back(d);
      if (drop_m) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      if (drop_m && clr) ocnt_m = 1;
      else if (clr) ocnt_m = 0;
      else if (drop_m && ocnt_m < 255) ocnt_m++;
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit         r, v, rdy, clr;
    uart_byte_t d;
    int         e_cnt;
    bit         e_mv;
    uart_byte_t e_md;
    bit         e_ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Basic FWFT sequence, then the count==1 push+pop bypass case.
    tbl[0] = '{r:1, v:0, rdy:0, clr:0, d:8'h00, e_cnt:0, e_mv:0, e_md:8'h00, e_ovf:0};
    tbl[1] = '{r:0, v:1, rdy:0, clr:0, d:8'hA5, e_cnt:1, e_mv:1, e_md:8'hA5, e_ovf:0};
    tbl[2] = '{r:0, v:1, rdy:0, clr:0, d:8'h3C, e_cnt:2, e_mv:1, e_md:8'hA5, e_ovf:0};
    tbl[3] = '{r:0, v:0, rdy:1, clr:0, d:8'h00, e_cnt:1, e_mv:1, e_md:8'h3C, e_ovf:0};
    tbl[4] = '{r:0, v:0, rdy:1, clr:0, d:8'h00, e_cnt:0, e_mv:0, e_md:8'h00, e_ovf:0};
    tbl[5] = '{r:0, v:1, rdy:0, clr:0, d:8'h11, e_cnt:1, e_mv:1, e_md:8'h11, e_ovf:0};
    tbl[6] = '{r:0, v:1, rdy:1, clr:0, d:8'h22, e_cnt:1, e_mv:1, e_md:8'h22, e_ovf:0};
    tbl[7] = '{r:0, v:0, rdy:1, clr:0, d:8'h00, e_cnt:0, e_mv:0, e_md:8'h00, e_ovf:0};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk("vec_count", int'(count), tbl[i].e_cnt);
      chk("vec_m_valid", int'(m_valid), int'(tbl[i].e_mv));
      if (tbl[i].e_mv) chk("vec_m_data", int'(m_data), int'(tbl[i].e_md));
      chk("vec_overflow", int'(overflow), int'(tbl[i].e_ovf));
      if (i == 0) chk("rst_empty", int'(empty), 1);
    end

    // Fill to full, check thresholds, then drop one frame.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, uart_byte_t'(i), 0, 0);
      chk("fill_afull", int'(almost_full), int'(i + 1 >= 12));
      chk("fill_full", int'(full), int'(i == 15));
    end
    chk("fill_no_ovf", int'(overflow), 0);
    step(0, 1, 8'hFF, 0, 0);
    chk("drop_ovf", int'(overflow), 1);
    chk("drop_count", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", int'(m_data), i);
      step(0, 0, 8'h00, 1, 0);
    end
    chk("drain_empty", int'(empty), 1);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf_cleared", int'(overflow), 0);

    // Full FIFO with simultaneous push and pop: write accepted, no drop.
    for (int i = 0; i < 16; i++) step(0, 1, uart_byte_t'(8'h20 + i), 0, 0);
    step(0, 1, 8'h77, 1, 0);
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_ovf", int'(overflow), 0);
    chk("fullpp_head", int'(m_data), 8'h21);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fullpp_last", int'(m_data), 8'h77);
      step(0, 0, 8'h00, 1, 0);
    end

    // Random traffic across many pointer wraps.
    for (int i = 0; i < 400; i++) begin
      step(0, 1'($urandom_range(0, 1)), uart_byte_t'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
      chk("rand_cnt_bound", int'(count <= 5'd16), 1);
    end
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom_range(0, 3) != 0), uart_byte_t'($urandom), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 31) == 0));

    // Mid-stream reset with stored entries and overflow set.
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, uart_byte_t'(8'h40 + i), 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, 8'h00, 1, 0);
    chk("pre_rst_count", int'(count), 5);
    chk("pre_rst_ovf", int'(overflow), 1);
    step(1, 1, 8'h99, 1, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty2", int'(empty), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Drop coinciding with ovf_clr: set wins.
    for (int i = 0; i < 16; i++) step(0, 1, uart_byte_t'(i), 0, 0);
    step(0, 1, 8'hEE, 0, 1);
    chk("drop_clr_ovf", int'(overflow), 1);

`ifdef UART_RX_FIFO_OVF_CNT_EN
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hD0, 0, 0);
    chk("ocnt_3", int'(ovf_cnt), 3);
    step(0, 0, 8'h00, 0, 1);
    chk("ocnt_clr", int'(ovf_cnt), 0);
    step(0, 1, 8'hD1, 0, 1);
    chk("ocnt_drop_clr", int'(ovf_cnt), 1);
    for (int i = 0; i < 260; i++) step(0, 1, 8'hD2, 0, 0);
    chk("ocnt_sat", int'(ovf_cnt), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
